mem_stage_controller: RTL and testbench



---
 rtl/mem_stage_controller.sv | 113 +++++++++++
 tb/tb_mem_stage_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_controller.sv
// MEM stage: issues aligned loads/stores on a req/ack port and loads MEM/WB every cycle; an aligned access costs at least one bubble.
// Combinational stall holds upstream while a request is outstanding; misaligned or timed-out accesses retire as bubbles.
module mem_stage_controller #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inMemToReg,
   input  logic        inRegWrite,
   input  logic        inMemRead,
   input  logic        inMemWrite,
   input  logic [31:0] inALUResult,
   input  logic [31:0] inWriteData,
   input  logic [4:0]  inWriteReg,
   output logic        stall,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   input  logic [31:0] memRdata,
   input  logic        memAck,
   output logic        outMemToReg,
   output logic        outRegWrite,
   output logic [31:0] outReadData,
   output logic [31:0] outALUResult,
   output logic [4:0]  outWriteReg,
   output logic        misalignErr,
   output logic        timeoutErr
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       access;
   logic       aligned;
   logic       cnt_last;

   assign access   = inMemRead | inMemWrite;
   assign aligned  = (inALUResult[1:0] == 2'b00);
   assign cnt_last = (cnt == CNT_LAST);
   assign memReq   = (state == ACCESS);

   // memAck takes priority over the timeout in the final ACCESS cycle
   always_comb begin
      stall = 1'b0;
      if (state == IDLE) stall = access & aligned;
      else               stall = ~memAck & ~cnt_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         memWe        <= 1'b0;
         memAddr      <= 32'd0;
         memWdata     <= 32'd0;
         outMemToReg  <= 1'b0;
         outRegWrite  <= 1'b0;
         outReadData  <= 32'd0;
         outALUResult <= 32'd0;
         outWriteReg  <= 5'd0;
         misalignErr  <= 1'b0;
         timeoutErr   <= 1'b0;
      end else begin
         // every cycle retires a bubble unless a branch below loads real fields
         misalignErr  <= 1'b0;
         timeoutErr   <= 1'b0;
         outMemToReg  <= 1'b0;
         outRegWrite  <= 1'b0;
         outReadData  <= 32'd0;
         outALUResult <= 32'd0;
         outWriteReg  <= 5'd0;
         case (state)
            IDLE: begin
               if (!access) begin
                  outMemToReg  <= inMemToReg;
                  outRegWrite  <= inRegWrite;
                  outALUResult <= inALUResult;
                  outWriteReg  <= inWriteReg;
               end else if (!aligned) begin
                  misalignErr <= 1'b1;
               end else begin
                  state    <= ACCESS;
                  cnt      <= 8'd0;
                  memAddr  <= inALUResult;
                  memWdata <= inWriteData;
                  memWe    <= inMemWrite;
               end
            end
            ACCESS: begin
               if (memAck) begin
                  state        <= IDLE;
                  outMemToReg  <= inMemToReg;
                  outRegWrite  <= inRegWrite;
                  outALUResult <= inALUResult;
                  outWriteReg  <= inWriteReg;
                  outReadData  <= (inMemRead & ~inMemWrite) ? memRdata : 32'd0;
               end else if (cnt_last) begin
                  state      <= IDLE;
                  timeoutErr <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_controller.sv
// Bench for mem_stage_controller: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_stage_controller;

   localparam int ACK_T = 4;

   typedef struct packed {
      logic        mtr;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  wr;
   } instr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inMemToReg = 1'b0, inRegWrite = 1'b0, inMemRead = 1'b0, inMemWrite = 1'b0;
   logic [31:0] inALUResult = '0, inWriteData = '0;
   logic [4:0]  inWriteReg = '0;
   logic        stall, memReq, memWe;
   logic [31:0] memAddr, memWdata;
   logic [31:0] memRdata = '0;
   logic        memAck = 1'b0;
   logic        outMemToReg, outRegWrite;
   logic [31:0] outReadData, outALUResult;
   logic [4:0]  outWriteReg;
   logic        misalignErr, timeoutErr;

   int vectors = 0;
   int miscompares = 0;

   // model state: one outstanding transaction and how many unanswered request cycles it has seen
   bit          m_pending = 0;
   int          m_waited = 0;
   bit          m_stall = 0;
   logic        e_req, e_we, e_mtr, e_rw, e_mis, e_tmo;
   logic [31:0] e_addr, e_wdata, e_rd, e_alu;
   logic [4:0]  e_wr;

   logic seen_stall, seen_req;

   mem_stage_controller #(.ACK_TIMEOUT(ACK_T)) dut (
      .clk(clk), .rst(rst),
      .inMemToReg(inMemToReg), .inRegWrite(inRegWrite),
      .inMemRead(inMemRead), .inMemWrite(inMemWrite),
      .inALUResult(inALUResult), .inWriteData(inWriteData), .inWriteReg(inWriteReg),
      .stall(stall), .memReq(memReq), .memWe(memWe),
      .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .memAck(memAck),
      .outMemToReg(outMemToReg), .outRegWrite(outRegWrite),
      .outReadData(outReadData), .outALUResult(outALUResult), .outWriteReg(outWriteReg),
      .misalignErr(misalignErr), .timeoutErr(timeoutErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wb_bubble();
      e_mtr = 0; e_rw = 0; e_rd = 0; e_alu = 0; e_wr = 0;
   endtask

   task automatic wb_load(input instr_t ins, input logic [31:0] rd);
      e_mtr = ins.mtr; e_rw = ins.rw; e_rd = rd; e_alu = ins.alu; e_wr = ins.wr;
   endtask

   task automatic model(input instr_t ins, input logic ack, input logic [31:0] rdata, input logic r);
      if (r) begin
         m_pending = 0; m_waited = 0; m_stall = 0;
         e_we = 0; e_addr = 0; e_wdata = 0; e_mis = 0; e_tmo = 0;
         wb_bubble();
      end else begin
         e_mis = 0; e_tmo = 0;
         if (!m_pending) begin
            if (!(ins.mr || ins.mw)) begin
               m_stall = 0; wb_load(ins, 0);
            end else if (ins.alu % 4 != 0) begin
               m_stall = 0; wb_bubble(); e_mis = 1;
            end else begin
               m_stall = 1; wb_bubble();
               m_pending = 1; m_waited = 0;
               e_we = ins.mw; e_addr = ins.alu; e_wdata = ins.wd;
            end
         end else if (ack) begin
            m_stall = 0; m_pending = 0;
            wb_load(ins, (ins.mr && !ins.mw) ? rdata : 32'd0);
         end else begin
            m_waited++;
            wb_bubble();
            if (m_waited == ACK_T) begin
               m_stall = 0; m_pending = 0; e_tmo = 1;
            end else begin
               m_stall = 1;
            end
         end
      end
      e_req = m_pending;
   endtask

   // one clock: drive at negedge, check stall mid-cycle, check registered outputs just after posedge
   task automatic step(input instr_t ins, input logic ack, input logic [31:0] rdata, input logic r);
      @(negedge clk);
      rst = r;
      inMemToReg = ins.mtr; inRegWrite = ins.rw; inMemRead = ins.mr; inMemWrite = ins.mw;
      inALUResult = ins.alu; inWriteData = ins.wd; inWriteReg = ins.wr;
      memAck = ack; memRdata = rdata;
      #1;
      seen_req = memReq;
      seen_stall = stall;
      model(ins, ack, rdata, r);
      if (!r) chk("stall", stall, m_stall);
      @(posedge clk);
      #1;
      chk("memReq", memReq, e_req);
      chk("memWe", memWe, e_we);
      chk("memAddr", memAddr, e_addr);
      chk("memWdata", memWdata, e_wdata);
      chk("outMemToReg", outMemToReg, e_mtr);
      chk("outRegWrite", outRegWrite, e_rw);
      chk("outReadData", outReadData, e_rd);
      chk("outALUResult", outALUResult, e_alu);
      chk("outWriteReg", outWriteReg, e_wr);
      chk("misalignErr", misalignErr, e_mis);
      chk("timeoutErr", timeoutErr, e_tmo);
   endtask

   function automatic instr_t mk(input logic mtr, input logic rw, input logic mr, input logic mw,
                                 input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
      instr_t t;
      t.mtr = mtr; t.rw = rw; t.mr = mr; t.mw = mw; t.alu = alu; t.wd = wd; t.wr = wr;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      int kind;
      kind  = $urandom_range(0, 4);
      t.alu = $urandom;
      if ($urandom_range(0, 3) != 0) t.alu[1:0] = 2'b00;
      t.wd  = $urandom;
      t.wr  = 5'($urandom);
      t.mr  = (kind == 2) || (kind == 4);
      t.mw  = (kind == 3) || (kind == 4);
      t.mtr = t.mr;
      t.rw  = (kind != 3) ? 1'b1 : 1'b0;
      return t;
   endfunction

   instr_t nop, cur;
   int     cnt_stall, cnt_req;

   initial begin
      nop = mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // reset state
      step(nop, 0, 0, 1);
      step(nop, 0, 0, 1);
      chk("reset_memReq", memReq, 0);
      chk("reset_outALUResult", outALUResult, 0);
      chk("reset_errs", {misalignErr, timeoutErr}, 0);

      // plain ALU op
      step(mk(0, 1, 0, 0, 32'h1234, 32'h0, 5'd5), 0, 0, 0);
      chk("alu_stall", seen_stall, 0);
      chk("alu_result", outALUResult, 32'h1234);
      chk("alu_regwrite", outRegWrite, 1);
      chk("alu_writereg", outWriteReg, 5);
      chk("alu_readdata", outReadData, 0);

      // load 0x100, ack two cycles after memReq rises
      cur = mk(1, 1, 1, 0, 32'h100, 32'h0, 5'd7);
      cnt_stall = 0;
      step(cur, 0, 0, 0); cnt_stall += int'(seen_stall);
      chk("ld_addr", memAddr, 32'h100);
      chk("ld_we", memWe, 0);
      step(cur, 0, 0, 0); cnt_stall += int'(seen_stall);
      step(cur, 0, 0, 0); cnt_stall += int'(seen_stall);
      step(cur, 1, 32'hDEADBEEF, 0); cnt_stall += int'(seen_stall);
      chk("ld_stall_cycles", cnt_stall, 3);
      chk("ld_readdata", outReadData, 32'hDEADBEEF);
      chk("ld_memtoreg", outMemToReg, 1);

      // store 0x40, ack in first ACCESS cycle
      cur = mk(0, 0, 0, 1, 32'h40, 32'hA5A5A5A5, 5'd0);
      cnt_stall = 0;
      step(cur, 0, 0, 0); cnt_stall += int'(seen_stall);
      chk("st_we", memWe, 1);
      chk("st_wdata", memWdata, 32'hA5A5A5A5);
      step(cur, 1, 32'h11111111, 0); cnt_stall += int'(seen_stall);
      chk("st_stall_cycles", cnt_stall, 1);
      chk("st_readdata", outReadData, 0);

      // misaligned load
      step(mk(1, 1, 1, 0, 32'h102, 32'h0, 5'd3), 0, 0, 0);
      chk("mis_stall", seen_stall, 0);
      chk("mis_err", misalignErr, 1);
      chk("mis_req", memReq, 0);
      chk("mis_regwrite", outRegWrite, 0);
      step(nop, 0, 0, 0);
      chk("mis_pulse_end", misalignErr, 0);

      // timeout with no ack
      cur = mk(1, 1, 1, 0, 32'h200, 32'h0, 5'd9);
      cnt_req = 0;
      step(cur, 0, 0, 0);
      for (int i = 0; i < ACK_T; i++) begin
         step(cur, 0, 0, 0);
         cnt_req += int'(seen_req);
      end
      chk("tmo_req_cycles", cnt_req, ACK_T);
      chk("tmo_last_stall", seen_stall, 0);
      chk("tmo_err", timeoutErr, 1);
      chk("tmo_bubble", outRegWrite, 0);
      step(nop, 0, 0, 0);
      chk("tmo_pulse_end", timeoutErr, 0);

      // ack arrives in the final allowed cycle
      step(cur, 0, 0, 0);
      for (int i = 0; i < ACK_T - 1; i++) step(cur, 0, 0, 0);
      step(cur, 1, 32'hCAFE0001, 0);
      chk("late_ack_err", timeoutErr, 0);
      chk("late_ack_data", outReadData, 32'hCAFE0001);

      // reset during the second ACCESS cycle, then a clean load
      step(cur, 0, 0, 0);
      step(cur, 0, 0, 0);
      step(cur, 0, 0, 1);
      chk("rst_req", memReq, 0);
      chk("rst_addr", memAddr, 0);
      chk("rst_errs", {misalignErr, timeoutErr}, 0);
      step(cur, 0, 0, 0);
      step(cur, 1, 32'h0BADF00D, 0);
      chk("post_rst_data", outReadData, 32'h0BADF00D);

      // randomized traffic; inputs held while the model says stall
      for (int i = 0; i < 3000; i++) begin
         if (!m_stall) cur = rand_instr();
         step(cur, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 99) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
